// File: rtl/present_lifecycle_ctrl.sv
// Lifecycle controller for one present slot: spawn, fall once per frame,
// rest on the floor, blink, then expire, unless a collision collects it first.
// Event outputs (collected, expired) are single-cycle pulses with no handshake.
// A pulse is asserted for exactly one clock and there is no back-pressure.
// collectedType is meaningful only while collected is high.
module present_lifecycle_ctrl #(
  parameter int PRESENT_W     = 32,
  parameter int PRESENT_H     = 32,
  parameter int SCREEN_W      = 640,
  parameter int FLOOR_Y       = 440,
  parameter int FALL_SPEED    = 2,
  parameter int LAND_FRAMES   = 180,
  parameter int BLINK_FRAMES  = 60,
  parameter int BLINK_HALF    = 8,
  parameter int ROPE_COLLECTS = 0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        spawnReq,
  input  logic [10:0] spawnX,
  input  logic [10:0] spawnY,
  input  logic [1:0]  spawnType,
  input  logic        col_player_present,
  input  logic        col_rope_present,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        presentVisible,
  output logic [1:0]  presentType,
  output logic        busy,
  output logic        collected,
  output logic [1:0]  collectedType,
  output logic        expired,
  output logic [1:0]  dbg_state
);

  localparam int CNT_MAX = (LAND_FRAMES > BLINK_FRAMES) ? LAND_FRAMES : BLINK_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [11:0] X_MAX   = 12'(SCREEN_W - PRESENT_W);
  localparam logic [11:0] Y_REST  = 12'(FLOOR_Y - PRESENT_H);
  localparam logic [11:0] H_12    = 12'(PRESENT_H);
  localparam logic [11:0] FLOOR12 = 12'(FLOOR_Y);
  localparam logic [11:0] SPEED12 = 12'(FALL_SPEED);

  localparam logic [CNT_W-1:0] LAND_LAST  = CNT_W'(LAND_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_DIV  = CNT_W'(BLINK_HALF);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FALLING  = 2'd1,
    S_LANDED   = 2'd2,
    S_BLINKING = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [10:0]      x_q, x_d, y_q, y_d;
  logic [1:0]       type_q, type_d, ctype_q, ctype_d;
  logic             collected_q, collected_d;
  logic             expired_q, expired_d;
  logic             visible_q, visible_d;
  logic             busy_q, busy_d;

  logic             rope_en;
  logic             hit;
  logic [11:0]      y_step;
  logic [CNT_W-1:0] blink_bit;

  assign rope_en = (ROPE_COLLECTS != 0);
  assign hit     = col_player_present | (rope_en & col_rope_present);

  // Next-state, position, timer and output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    type_d      = type_q;
    ctype_d     = '0;
    collected_d = 1'b0;
    expired_d   = 1'b0;
    visible_d   = 1'b0;
    blink_bit   = '0;
    y_step      = {1'b0, y_q} + SPEED12;

    case (state_q)
      S_IDLE: begin
        // Collisions are meaningless without a present on screen.
        if (spawnReq) begin
          type_d = spawnType;
          x_d    = ({1'b0, spawnX} > X_MAX) ? X_MAX[10:0] : spawnX;
          cnt_d  = '0;
          if (({1'b0, spawnY} + H_12) >= FLOOR12) begin
            y_d     = Y_REST[10:0];
            state_d = S_LANDED;
          end else begin
            y_d     = spawnY;
            state_d = S_FALLING;
          end
        end
      end
      default: begin
        // Collection beats frame motion/timers; a frame tick in the same
        // cycle is swallowed so the present neither moves nor expires.
        if (hit) begin
          collected_d = 1'b1;
          ctype_d     = type_q;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end else if (startOfFrame) begin
          case (state_q)
            S_FALLING: begin
              if ((y_step + H_12) >= FLOOR12) begin
                y_d     = Y_REST[10:0];
                cnt_d   = '0;
                state_d = S_LANDED;
              end else begin
                y_d = y_step[10:0];
              end
            end
            S_LANDED: begin
              if (cnt_q == LAND_LAST) begin
                cnt_d   = '0;
                state_d = S_BLINKING;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end
            default: begin
              if (cnt_q == BLINK_LAST) begin
                expired_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_IDLE;
              end else begin
                cnt_d = cnt_q + CNT_ONE;
              end
            end
          endcase
        end
      end
    endcase

    // Visibility follows the state being entered so it is registered
    // alongside it; blinking starts with a visible half-period.
    blink_bit = (cnt_d / BLINK_DIV) & CNT_ONE;
    case (state_d)
      S_FALLING, S_LANDED: visible_d = 1'b1;
      S_BLINKING:          visible_d = (blink_bit == '0);
      default:             visible_d = 1'b0;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; synchronous active-low reset wins over everything.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      type_q      <= '0;
      ctype_q     <= '0;
      collected_q <= 1'b0;
      expired_q   <= 1'b0;
      visible_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      type_q      <= type_d;
      ctype_q     <= ctype_d;
      collected_q <= collected_d;
      expired_q   <= expired_d;
      visible_q   <= visible_d;
      busy_q      <= busy_d;
    end
  end

  assign topLeftX       = x_q;
  assign topLeftY       = y_q;
  assign presentVisible = visible_q;
  assign presentType    = type_q;
  assign busy           = busy_q;
  assign collected      = collected_q;
  assign collectedType  = ctype_q;
  assign expired        = expired_q;
  assign dbg_state      = state_q;

endmodule
